// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus controller: state encoding and the
// default abort limit for a memory access.
package mem_bus_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_FIN     = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  localparam logic [7:0] DEFAULT_TIMEOUT = 8'd16;

  function automatic logic isWaitState(input logic [2:0] state);
    return (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// Eight-bit wait-cycle counter; flags expiry on the cycle whose increment
// would bring the count up to LIMIT.
module mem_bus_timer
  import mem_bus_pkg::*;
#(
  parameter logic [7:0] LIMIT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [7:0] LAST = LIMIT - 8'd1;

  logic [7:0] r_count;

  // Saturates so a stuck enable can never wrap back below the limit.
  always_ff @(posedge i_clk) begin
    if (i_clr || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count >= LAST);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns single-cycle read/write requests into strobed
// memory accesses with variable-latency acknowledge and timeout abort.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [15:0] MAR_in,
  input  logic [15:0] MDR_in,
  input  logic        RD_req,
  input  logic        WR_req,
  output logic [15:0] M_bus_in,
  output logic        MMD_load,
  output logic        BUSY,
  output logic        DONE,
  output logic        BUS_ERR,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_addrQ;
  logic [15:0] r_wdataQ;
  logic [15:0] r_mBus;
  logic        r_isRead;
  logic        r_mmdLoad;
  logic        r_busy;
  logic        r_done;
  logic        r_busErr;
  logic        r_memRe;
  logic        r_memWe;
  logic        w_timerClear;
  logic        w_timerEnable;
  logic        w_expired;

  mem_bus_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .i_clk    (CLK),
    .i_clr    (CLR),
    .i_clear  (w_timerClear),
    .i_enable (w_timerEnable),
    .o_expired(w_expired)
  );

  // Ack is checked before expiry so a last-moment acknowledge still succeeds.
  always_comb begin
    w_next        = r_state;
    w_timerClear  = 1'b0;
    w_timerEnable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timerClear = 1'b1;
        if (RD_req && !WR_req) begin
          w_next = ST_RD_WAIT;
        end else if (WR_req && !RD_req) begin
          w_next = ST_WR_WAIT;
        end else if (RD_req && WR_req) begin
          w_next = ST_ERR;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_ack) begin
          w_next = ST_FIN;
        end else begin
          w_timerEnable = 1'b1;
          if (w_expired) begin
            w_next = ST_ERR;
          end
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Every output is a flop loaded from the upcoming state, so strobes and
  // pulses line up exactly with the state they describe.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state   <= ST_IDLE;
      r_addrQ   <= '0;
      r_wdataQ  <= '0;
      r_mBus    <= '0;
      r_isRead  <= 1'b0;
      r_mmdLoad <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_busErr  <= 1'b0;
      r_memRe   <= 1'b0;
      r_memWe   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) begin
        if (w_next == ST_RD_WAIT) begin
          r_addrQ  <= MAR_in;
          r_isRead <= 1'b1;
        end else if (w_next == ST_WR_WAIT) begin
          r_addrQ  <= MAR_in;
          r_wdataQ <= MDR_in;
          r_isRead <= 1'b0;
        end
      end
      if ((r_state == ST_RD_WAIT) && mem_ack) begin
        r_mBus <= mem_rdata;
      end
      r_memRe   <= (w_next == ST_RD_WAIT);
      r_memWe   <= (w_next == ST_WR_WAIT);
      r_busy    <= (w_next != ST_IDLE);
      r_done    <= (w_next == ST_FIN);
      r_mmdLoad <= (w_next == ST_FIN) && isWaitState(r_state) && (r_state == ST_RD_WAIT);
      r_busErr  <= (w_next == ST_ERR);
    end
  end

  assign M_bus_in  = r_mBus;
  assign MMD_load  = r_mmdLoad;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign BUS_ERR   = r_busErr;
  assign mem_addr  = r_addrQ;
  assign mem_wdata = r_wdataQ;
  assign mem_re    = r_memRe;
  assign mem_we    = r_memWe;

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd16: max wait cycles for mem_ack before abort, legal range 1..255.
REQ-002 SHALL have CLK  in  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have CLR  in  1  reset, synchronous, active-high.
REQ-004 SHALL have MAR_in  in  16  access address, taken from the datapath MAR output.
REQ-005 SHALL have MDR_in  in  16  write data, taken from the datapath MDR-to-M-bus output.
REQ-006 SHALL have RD_req  in  1  read request from the controller.
REQ-007 SHALL have WR_req  in  1  write request from the controller.
REQ-008 SHALL have M_bus_in  out  16  read data to the datapath M bus.
REQ-009 SHALL have MMD_load  out  1  one-cycle strobe: M_bus_in is valid, MDR latches it.
REQ-010 SHALL have BUSY  out  1  an access is in progress.
REQ-011 SHALL have DONE  out  1  one-cycle pulse: access completed successfully.
REQ-012 SHALL have BUS_ERR  out  1  one-cycle pulse: access aborted or request rejected.
REQ-013 SHALL have mem_addr  out  16  memory address.
REQ-014 SHALL have mem_wdata  out  16  memory write data.
REQ-015 SHALL have mem_re  out  1  memory read strobe.
REQ-016 SHALL have mem_we  out  1  memory write strobe.
REQ-017 SHALL have mem_rdata  in  16  memory read data.
REQ-018 SHALL have mem_ack  in  1  memory completion acknowledge, variable latency.

Function
REQ-019 SHALL implement states IDLE, RD_WAIT, WR_WAIT, FIN, ERR; all outputs SHALL be registered.
REQ-020 In IDLE, RD_req=1 with WR_req=0 SHALL latch MAR_in into addr_q and enter RD_WAIT.
REQ-021 In IDLE, WR_req=1 with RD_req=0 SHALL latch MAR_in into addr_q, latch MDR_in into wdata_q, and enter WR_WAIT.
REQ-022 In IDLE, RD_req=WR_req=1 SHALL start no access and enter ERR (protocol error).
REQ-023 In RD_WAIT, mem_re SHALL be 1; in WR_WAIT, mem_we SHALL be 1; in all other states, mem_re=mem_we=0; mem_addr SHALL equal addr_q and mem_wdata SHALL equal wdata_q.
REQ-024 A wait state SHALL exit on the first cycle mem_ack=1: RD_WAIT captures mem_rdata into M_bus_in; both wait states then enter FIN.
REQ-025 FIN SHALL last one cycle, then return to IDLE: DONE=1 in that cycle; MMD_load=1 in that cycle only when the access was a read.
REQ-026 Latency: request sampled at edge N; strobe high from cycle N+1; ack sampled at edge N+k; DONE high in cycle N+k+1. Minimum request-to-DONE is 2 cycles.
REQ-027 A wait counter SHALL clear on entry to a wait state and increment each wait cycle without ack.
REQ-028 When the wait counter reaches TIMEOUT, the access SHALL abort: strobes drop, ERR is entered, M_bus_in is unchanged, DONE and MMD_load stay 0.
REQ-029 ERR SHALL last one cycle with BUS_ERR=1, then return to IDLE.
REQ-030 BUSY SHALL be 1 in RD_WAIT, WR_WAIT, FIN and ERR.
REQ-031 Requests arriving while BUSY=1 SHALL be ignored, not queued.
REQ-032 mem_ack SHALL be ignored outside the wait states.
REQ-033 mem_ack and timeout in the same cycle: ack SHALL win.
REQ-034 M_bus_in SHALL hold the last successfully read value until the next successful read.

Reset
REQ-035 CLR=1 at a rising edge SHALL force IDLE and clear M_bus_in, addr_q, wdata_q and the wait counter to 0; MMD_load, BUSY, DONE, BUS_ERR, mem_re and mem_we SHALL be 0.
REQ-036 CLR asserted mid-access SHALL abort the access with no DONE and no BUS_ERR.
REQ-037 CLR SHALL take priority over every other input.

Structure
REQ-038 Package mem_bus_pkg SHALL hold the state encoding and the default TIMEOUT constant.
REQ-039 The wait counter SHALL be a sub-module, mem_bus_timer: 8-bit, with clear, enable, and an expired output.

Verification
REQ-040 Read, MAR_in=16'h0100, mem_ack after 3 wait cycles with mem_rdata=16'hBEEF -> DONE and MMD_load high in the same single cycle; M_bus_in=16'hBEEF.
REQ-041 Write, MAR_in=16'hF800, MDR_in=16'h1234, mem_ack on the first wait cycle -> mem_we for 1 cycle with mem_addr=16'hF800 and mem_wdata=16'h1234; DONE at request+2; MMD_load=0.
REQ-042 Read with TIMEOUT=4 and no mem_ack -> mem_re for 4 cycles, then BUS_ERR pulse; M_bus_in keeps its prior value; DONE=0.
REQ-043 RD_req=WR_req=1 in IDLE -> BUS_ERR next cycle; mem_re=mem_we=0 throughout.
REQ-044 CLR pulsed during RD_WAIT -> all outputs 0 next cycle; a late mem_ack is ignored; a new read afterwards completes normally.
REQ-045 WR_req pulsed during BUSY, then mem_ack=1 while in IDLE -> no second access and no spurious DONE.
